// File: rtl/stream_scheduler.sv
// rtl/stream_scheduler.sv - FIFO-to-sink sample scheduler (UART / I2S 2 Hz / I2S 44.1 kHz)
//
// Purpose: reads samples from the sample FIFO and hands each one to exactly
// one sink. It waits for a FIFO prefill before streaming, paces the slow
// I2S mode from an internal tick, switches modes cleanly and counts underruns.
//
// Optional feature macro: STREAM_SCHED_UNDERRUN_REPEAT_EN
//   When defined, an underrun in an I2S mode re-issues the last out_sample
//   instead of going back to prefill. Mode 00 underruns are unchanged.
//
// Ports:
//   in_clk, in_reset       clock, asynchronous active-high reset
//   in_mode[1:0]           00 UART, 01 I2S slow rate, 10 I2S 44.1 kHz, 11 idle
//   in_fifo_dout[BPS]      FIFO read data, valid the cycle after out_fifo_rd_en
//   in_fifo_empty          FIFO empty flag
//   in_fifo_prog_empty     FIFO below prefill threshold
//   in_uart_ready          UART sink can accept a sample
//   in_i2s_ready           I2S sink can accept a sample
//   out_fifo_rd_en         FIFO read strobe (1 cycle)
//   out_sample[BPS]        sample presented to the selected sink
//   out_uart_en            UART load strobe (1 cycle)
//   out_i2s_en             I2S load strobe (1 cycle, both I2S modes)
//   out_underrun_cnt[CNT_W] saturating underrun count
//   out_state[2:0]         FSM state for debug
module stream_scheduler #(
  parameter int BPS          = 24,
  parameter int CLK_HZ       = 61440000,
  parameter int SLOW_RATE_HZ = 2,
  parameter int CNT_W        = 16
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic [1:0]       in_mode,
  input  logic [BPS-1:0]   in_fifo_dout,
  input  logic             in_fifo_empty,
  input  logic             in_fifo_prog_empty,
  input  logic             in_uart_ready,
  input  logic             in_i2s_ready,
  output logic             out_fifo_rd_en,
  output logic [BPS-1:0]   out_sample,
  output logic             out_uart_en,
  output logic             out_i2s_en,
  output logic [CNT_W-1:0] out_underrun_cnt,
  output logic [2:0]       out_state
);

  localparam int PACE_P = CLK_HZ / SLOW_RATE_HZ;
  localparam int PACE_W = (PACE_P > 1) ? $clog2(PACE_P) : 1;

  localparam logic [1:0] MODE_UART = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    READY   = 3'd2,
    LATCH   = 3'd3,
    ISSUE   = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          cur_mode, cur_mode_nxt;
  logic                mode_load;
  logic                issue;
  logic                go_cond;
  logic                rd_en_nxt, uart_en_nxt, i2s_en_nxt;
  logic [CNT_W-1:0]    underrun_nxt;
  logic [PACE_W-1:0]   pace_cnt;
  logic                pace_wrap;
  logic                tick_pending;
  // High in the cycle after the FIFO read strobe, i.e. when in_fifo_dout
  // carries the requested word. A repeat issue never has this set, so the
  // held sample is kept.
  logic                dout_valid;

  assign out_state = state;
  assign pace_wrap = (pace_cnt == PACE_W'(PACE_P - 1));

  always_comb begin
    go_cond = 1'b0;
    case (cur_mode)
      MODE_UART: go_cond = in_uart_ready;
      MODE_SLOW: go_cond = in_i2s_ready & tick_pending;
      MODE_FAST: go_cond = in_i2s_ready;
      default:   go_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    cur_mode_nxt = cur_mode;
    mode_load    = 1'b0;
    issue        = 1'b0;
    rd_en_nxt    = 1'b0;
    uart_en_nxt  = 1'b0;
    i2s_en_nxt   = 1'b0;
    underrun_nxt = out_underrun_cnt;
    case (state)
      IDLE: begin
        if (in_mode != MODE_IDLE) begin
          cur_mode_nxt = in_mode;
          mode_load    = 1'b1;
          state_nxt    = PREFILL;
        end
      end
      PREFILL: begin
        if (in_mode != cur_mode)  state_nxt = IDLE;
        else if (!in_fifo_prog_empty) state_nxt = READY;
      end
      READY: begin
        if (in_mode != cur_mode) begin
          state_nxt = IDLE;
        end else if (go_cond) begin
          if (!in_fifo_empty) begin
            rd_en_nxt = 1'b1;
            state_nxt = LATCH;
          end else begin
            if (out_underrun_cnt != {CNT_W{1'b1}})
              underrun_nxt = out_underrun_cnt + CNT_W'(1);
`ifdef STREAM_SCHED_UNDERRUN_REPEAT_EN
            state_nxt = (cur_mode == MODE_UART) ? PREFILL : ISSUE;
`else
            state_nxt = PREFILL;
`endif
          end
        end
      end
      LATCH: state_nxt = ISSUE;
      ISSUE: begin
        issue = 1'b1;
        if (cur_mode == MODE_UART) uart_en_nxt = 1'b1;
        else                       i2s_en_nxt  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state            <= IDLE;
      cur_mode         <= MODE_IDLE;
      out_fifo_rd_en   <= 1'b0;
      out_uart_en      <= 1'b0;
      out_i2s_en       <= 1'b0;
      out_sample       <= '0;
      out_underrun_cnt <= '0;
      dout_valid       <= 1'b0;
      pace_cnt         <= '0;
      tick_pending     <= 1'b0;
    end else begin
      state            <= state_nxt;
      cur_mode         <= cur_mode_nxt;
      out_fifo_rd_en   <= rd_en_nxt;
      out_uart_en      <= uart_en_nxt;
      out_i2s_en       <= i2s_en_nxt;
      out_underrun_cnt <= underrun_nxt;
      dout_valid       <= out_fifo_rd_en;
      if (dout_valid) out_sample <= in_fifo_dout;

      if (mode_load) begin
        pace_cnt     <= '0;
        tick_pending <= 1'b0;
      end else begin
        if (cur_mode == MODE_SLOW)
          pace_cnt <= pace_wrap ? '0 : pace_cnt + PACE_W'(1);
        // A wrap in the same cycle as an issue leaves the tick pending.
        if ((cur_mode == MODE_SLOW) && pace_wrap) tick_pending <= 1'b1;
        else if (issue)                           tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_scheduler.sv
// tb/tb_stream_scheduler.sv - directed self-checking bench for stream_scheduler
module tb_stream_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b11;
  logic [23:0] fifo_dout = '0;
  logic        fifo_empty, fifo_prog_empty;
  logic        uart_ready, i2s_ready;
  logic        rd_en, uart_en, i2s_en;
  logic [23:0] sample;
  logic [3:0]  underrun_cnt;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int prog_thr = 1;
  logic fifo_flush = 1'b0;
  logic clr_logs = 1'b0;
  logic uart_sink_on = 1'b0;
  logic i2s_sink_on = 1'b0;
  int uart_busy = 0;
  int i2s_busy = 0;
  int cyc = 0;
  int viol_excl = 0;
  int viol_rd = 0;
  logic [23:0] uart_log[$];
  logic [23:0] i2s_log[$];
  int i2s_t[$];

  always #5 clk = ~clk;

  stream_scheduler #(.BPS(24), .CLK_HZ(1000), .SLOW_RATE_HZ(2), .CNT_W(4)) dut (
    .in_clk(clk), .in_reset(rst), .in_mode(mode), .in_fifo_dout(fifo_dout),
    .in_fifo_empty(fifo_empty), .in_fifo_prog_empty(fifo_prog_empty),
    .in_uart_ready(uart_ready), .in_i2s_ready(i2s_ready),
    .out_fifo_rd_en(rd_en), .out_sample(sample), .out_uart_en(uart_en),
    .out_i2s_en(i2s_en), .out_underrun_cnt(underrun_cnt), .out_state(state)
  );

  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_prog_empty = ((wr_ptr - rd_ptr) < prog_thr);
  assign uart_ready      = uart_sink_on && (uart_busy == 0);
  assign i2s_ready       = i2s_sink_on && (i2s_busy == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
    if (uart_en) uart_busy <= 3;
    else if (uart_busy != 0) uart_busy <= uart_busy - 1;
    if (i2s_en) i2s_busy <= 2;
    else if (i2s_busy != 0) i2s_busy <= i2s_busy - 1;
  end

  always @(negedge clk) begin
    if (clr_logs) begin
      uart_log.delete();
      i2s_log.delete();
      i2s_t.delete();
    end else begin
      if (uart_en) uart_log.push_back(sample);
      if (i2s_en) begin
        i2s_log.push_back(sample);
        i2s_t.push_back(cyc);
      end
      if (uart_en && i2s_en) viol_excl <= viol_excl + 1;
      if (rd_en && fifo_empty) viol_rd <= viol_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode = 2'b11;
    uart_sink_on = 1'b0;
    i2s_sink_on = 1'b0;
    fifo_flush = 1'b1;
    clr_logs = 1'b1;
    repeat (4) @(negedge clk);
    fifo_flush = 1'b0;
    clr_logs = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_state", state, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_uart_en", uart_en, 0);
    check("rst_i2s_en", i2s_en, 0);
    check("rst_sample", sample, 0);
    check("rst_underrun", underrun_cnt, 0);

    // UART mode, four samples in order, then one underrun back to prefill.
    prog_thr = 2;
    for (int i = 1; i <= 4; i++) push(24'(i));
    uart_sink_on = 1'b1;
    mode = 2'b00;
    n = 0;
    while (uart_log.size() < 4 && n < 300) begin @(negedge clk); n++; end
    check("uart_done", (uart_log.size() >= 4), 1);
    for (int i = 0; i < 4; i++) check($sformatf("uart_data%0d", i), uart_log[i], i + 1);
    repeat (30) @(negedge clk);
    check("uart_no_i2s", i2s_log.size(), 0);
    check("uart_underrun", underrun_cnt, 1);
    check("uart_prefill", state, 1);

    // Slow I2S mode: strobes exactly P = 500 clocks apart.
    do_reset();
    prog_thr = 1;
    for (int i = 0; i < 8; i++) push(24'h000A00 + 24'(i));
    i2s_sink_on = 1'b1;
    mode = 2'b01;
    n = 0;
    while (i2s_log.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    check("slow_done", (i2s_log.size() >= 3), 1);
    check("slow_gap1", i2s_t[1] - i2s_t[0], 500);
    check("slow_gap2", i2s_t[2] - i2s_t[1], 500);
    check("slow_data0", i2s_log[0], 24'h000A00);
    check("slow_data2", i2s_log[2], 24'h000A02);
    check("slow_no_uart", uart_log.size(), 0);

    // Fast I2S mode drains to empty.
    do_reset();
    prog_thr = 1;
    push(24'h000B01);
    push(24'h000B02);
    i2s_sink_on = 1'b1;
    mode = 2'b10;
`ifdef STREAM_SCHED_UNDERRUN_REPEAT_EN
    n = 0;
    while (i2s_log.size() < 3 && n < 300) begin @(negedge clk); n++; end
    check("fast_done", (i2s_log.size() >= 3), 1);
    check("fast_underrun", underrun_cnt, 1);
    check("fast_repeat", i2s_log[2], 24'h000B02);
`else
    n = 0;
    while (i2s_log.size() < 2 && n < 300) begin @(negedge clk); n++; end
    check("fast_done", (i2s_log.size() >= 2), 1);
    repeat (30) @(negedge clk);
    check("fast_underrun", underrun_cnt, 1);
    check("fast_prefill", state, 1);
    check("fast_no_strobe", i2s_log.size(), 2);
`endif

    // Switch UART -> fast I2S while the first sample is in ISSUE.
    do_reset();
    prog_thr = 1;
    for (int i = 1; i <= 4; i++) push(24'h000C00 + 24'(i));
    uart_sink_on = 1'b1;
    i2s_sink_on = 1'b1;
    mode = 2'b00;
    n = 0;
    while (state != 3'd4 && n < 100) begin @(negedge clk); n++; end
    check("sw_issue_seen", state, 4);
    mode = 2'b10;
    n = 0;
    while ((uart_log.size() + i2s_log.size()) < 4 && n < 400) begin @(negedge clk); n++; end
    check("sw_uart_cnt", uart_log.size(), 1);
    check("sw_uart_data", uart_log[0], 24'h000C01);
    check("sw_i2s_cnt", i2s_log.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("sw_i2s%0d", i), i2s_log[i], 24'h000C02 + 24'(i));

    // Asynchronous reset while in LATCH on the second transfer.
    do_reset();
    prog_thr = 1;
    for (int i = 0; i < 6; i++) push(24'h0D0000 + 24'(i) + 24'h11);
    i2s_sink_on = 1'b1;
    mode = 2'b10;
    n = 0;
    while (i2s_log.size() < 1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (state != 3'd3 && n < 100) begin @(negedge clk); n++; end
    check("ar_latch_seen", state, 3);
    check("ar_sample_before", sample, 24'h0D0011);
    #2 rst = 1'b1;
    #1;
    check("ar_state", state, 0);
    check("ar_rd_en", rd_en, 0);
    check("ar_sample", sample, 0);
    check("ar_i2s_en", i2s_en, 0);
    check("ar_pace_cnt", dut.pace_cnt, 0);

    // Repeated underruns saturate the 4-bit counter.
    do_reset();
    prog_thr = 0;
    uart_sink_on = 1'b1;
    mode = 2'b00;
    repeat (12) @(negedge clk);
    check("sat_mid", (underrun_cnt > 0 && underrun_cnt < 4'hF), 1);
    repeat (100) @(negedge clk);
    check("sat_hold", underrun_cnt, 4'hF);

    check("excl_strobes", viol_excl, 0);
    check("rd_en_empty", viol_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
